// File: rtl/wb_stage_regfile_if.sv
// Writeback-stage bus: MEM/WB operands and decode read addresses in,
// bypassed read data, writeback bus and output port out.
interface wb_stage_regfile_if #(
    parameter int DATA_W = 8
);
    logic              wr_en_regf_W;
    logic              mux_out_sel_W;
    logic [1:0]        mux_rdata_sel_W;
    logic              out_port_sel_W;
    logic [1:0]        ADDER_W;
    logic [DATA_W-1:0] read_data_W;
    logic [DATA_W-1:0] alu_out_W;
    logic [DATA_W-1:0] IN_PORT_W;
    logic [DATA_W-1:0] RD2_W;
    logic              sp_wr_en;
    logic [DATA_W-1:0] sp_next;
    logic [1:0]        ra1;
    logic [1:0]        ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sp_out;
    logic [DATA_W-1:0] wb_data_W;
    logic              wb_valid_W;
    logic [DATA_W-1:0] OUT_PORT;
    logic              out_strobe;

    modport master (
        output wr_en_regf_W, mux_out_sel_W, mux_rdata_sel_W, out_port_sel_W, ADDER_W,
               read_data_W, alu_out_W, IN_PORT_W, RD2_W, sp_wr_en, sp_next, ra1, ra2,
        input  rd1, rd2, sp_out, wb_data_W, wb_valid_W, OUT_PORT, out_strobe
    );

    modport slave (
        input  wr_en_regf_W, mux_out_sel_W, mux_rdata_sel_W, out_port_sel_W, ADDER_W,
               read_data_W, alu_out_W, IN_PORT_W, RD2_W, sp_wr_en, sp_next, ra1, ra2,
        output rd1, rd2, sp_out, wb_data_W, wb_valid_W, OUT_PORT, out_strobe
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// Writeback stage: writeback mux, 4-entry register file (R3 = SP) with
// write-before-read bypass, and the registered OUT_PORT with its strobe.
module wb_stage_regfile #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] SP_INIT  = 8'hFF,
    parameter logic [DATA_W-1:0] OUT_INIT = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    wb_stage_regfile_if.slave  bus
);
    localparam int         NUM_REGS = 4;
    localparam logic [1:0] SP_IDX   = 2'd3;
    localparam logic [1:0] SEL_MEM  = 2'b00;
    localparam logic [1:0] SEL_IN   = 2'b01;
    localparam logic [1:0] SEL_RD2  = 2'b10;
    localparam logic [1:0] SEL_ALU  = 2'b11;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]               wb_data;
    logic [DATA_W-1:0]               out_port_q, out_port_d;
    logic                            out_strobe_q, out_strobe_d;

    always_comb begin
        wb_data = bus.alu_out_W;
        case (bus.mux_rdata_sel_W)
            SEL_MEM: wb_data = bus.mux_out_sel_W ? bus.read_data_W : bus.alu_out_W;
            SEL_IN:  wb_data = bus.IN_PORT_W;
            SEL_RD2: wb_data = bus.RD2_W;
            SEL_ALU: wb_data = bus.alu_out_W;
            default: wb_data = bus.alu_out_W;
        endcase
    end

    // Regular write is applied after the SP update so it wins an R3 collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.sp_wr_en)     regs_d[SP_IDX]      = bus.sp_next;
        if (bus.wr_en_regf_W) regs_d[bus.ADDER_W] = wb_data;
    end

    always_comb begin
        out_port_d   = bus.out_port_sel_W ? bus.RD2_W : out_port_q;
        out_strobe_d = bus.out_port_sel_W;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q       <= {SP_INIT, {((NUM_REGS-1)*DATA_W){1'b0}}};
            out_port_q   <= OUT_INIT;
            out_strobe_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            out_port_q   <= out_port_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    // Reading the next-state array gives the bypass with the same priority as the write.
    assign bus.rd1        = regs_d[bus.ra1];
    assign bus.rd2        = regs_d[bus.ra2];
    assign bus.sp_out     = regs_d[SP_IDX];
    assign bus.wb_data_W  = wb_data;
    assign bus.wb_valid_W = bus.wr_en_regf_W;
    assign bus.OUT_PORT   = out_port_q;
    assign bus.out_strobe = out_strobe_q;
endmodule
